multicycle_ctrl: RTL and testbench

- Main control FSM for the multicycle OTTER core.
- Sequences instruction fetch, decode, execute, memory access and writeback.
- Drives the immediate-generator select (immed_src), ALU, PC, register-file and memory strobes from the instruction register contents.
- Sits between the instruction register / branch-condition logic and the shared datapath muxes; owns no datapath storage of its own.

---
 rtl/multicycle_ctrl_pkg.sv | 79 +++++++
 rtl/multicycle_ctrl_decoder.sv | 93 +++++++++
 rtl/multicycle_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : otter_pkg
//  Description : Shared encodings for the multicycle OTTER control path:
//                opcodes, immediate formats, FSM states, instruction
//                classes, and the pc_src / rf_wr_sel / alu_fun constants.
//  Revision    : 1.0 - initial release
// ============================================================================
package otter_pkg;

    // RV32I major opcodes recognised by the controller
    typedef enum logic [6:0] {
        OPC_LUI    = 7'b0110111,
        OPC_AUIPC  = 7'b0010111,
        OPC_JAL    = 7'b1101111,
        OPC_JALR   = 7'b1100111,
        OPC_BRANCH = 7'b1100011,
        OPC_LOAD   = 7'b0000011,
        OPC_STORE  = 7'b0100011,
        OPC_OP_IMM = 7'b0010011,
        OPC_OP     = 7'b0110011
    } opcode_t;

    // Immediate format select, shared with the immediate generator
    typedef enum logic [2:0] {
        IMM_I = 3'd0,
        IMM_S = 3'd1,
        IMM_B = 3'd2,
        IMM_U = 3'd3,
        IMM_J = 3'd4
    } immed_src_t;

    // Controller states
    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd5
    } state_t;

    // Coarse instruction class used by the FSM to pick a sequence
    typedef enum logic [2:0] {
        CLS_ALU     = 3'd0,
        CLS_JAL     = 3'd1,
        CLS_JALR    = 3'd2,
        CLS_BRANCH  = 3'd3,
        CLS_LOAD    = 3'd4,
        CLS_STORE   = 3'd5,
        CLS_ILLEGAL = 3'd6
    } inst_class_t;

    // Next-PC select
    localparam logic [1:0] c_pc_src_plus4  = 2'd0;
    localparam logic [1:0] c_pc_src_jalr   = 2'd1;
    localparam logic [1:0] c_pc_src_branch = 2'd2;
    localparam logic [1:0] c_pc_src_jal    = 2'd3;

    // Register-file writeback select
    localparam logic [1:0] c_wr_sel_pc4 = 2'd0;
    localparam logic [1:0] c_wr_sel_csr = 2'd1;
    localparam logic [1:0] c_wr_sel_mem = 2'd2;
    localparam logic [1:0] c_wr_sel_alu = 2'd3;

    // ALU operation codes the controller produces directly
    localparam logic [3:0] c_alu_add = 4'b0000;
    localparam logic [3:0] c_alu_lui = 4'b1001;

    // funct3 value of the shift-right immediates (srli/srai)
    localparam logic [2:0] c_funct3_sr = 3'b101;

    // ALU code for OP_IMM: inst[30] only distinguishes srai from srli
    function automatic logic [3:0] f_alu_fun_op_imm(input logic bit30, input logic [2:0] funct3);
        return {(funct3 == c_funct3_sr) ? bit30 : 1'b0, funct3};
    endfunction

endpackage : otter_pkg
`default_nettype wire

// File: rtl/multicycle_ctrl_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : ctrl_decoder
//  Description : Purely combinational opcode/funct decode into the static
//                controls (immediate format, ALU op and operand selects,
//                writeback select) and the instruction class.
//  Revision    : 1.0 - initial release
// ============================================================================
module ctrl_decoder
    import otter_pkg::*;
(
    input  logic [31:0]  inst,
    output immed_src_t   immed_src,
    output logic [3:0]   alu_fun,
    output logic         alu_src_a,
    output logic         alu_src_b,
    output logic [1:0]   rf_wr_sel,
    output inst_class_t  inst_class
);

    // Fields not needed by the control path (register indices, upper funct7)
    logic w_unused_fields;
    assign w_unused_fields = ^{inst[31], inst[29:15], inst[11:7]};

    // Opcode decode; inst[1:0]!=11 never matches a known opcode, so it
    // falls into the illegal class through the default arm.
    always_comb begin
        immed_src  = IMM_I;
        alu_fun    = c_alu_add;
        alu_src_a  = 1'b0;
        alu_src_b  = 1'b0;
        rf_wr_sel  = c_wr_sel_pc4;
        inst_class = CLS_ILLEGAL;
        case (inst[6:0])
            OPC_OP: begin
                alu_fun    = {inst[30], inst[14:12]};
                rf_wr_sel  = c_wr_sel_alu;
                inst_class = CLS_ALU;
            end
            OPC_OP_IMM: begin
                immed_src  = IMM_I;
                alu_fun    = f_alu_fun_op_imm(inst[30], inst[14:12]);
                alu_src_b  = 1'b1;
                rf_wr_sel  = c_wr_sel_alu;
                inst_class = CLS_ALU;
            end
            OPC_LUI: begin
                immed_src  = IMM_U;
                alu_fun    = c_alu_lui;
                alu_src_b  = 1'b1;
                rf_wr_sel  = c_wr_sel_alu;
                inst_class = CLS_ALU;
            end
            OPC_AUIPC: begin
                immed_src  = IMM_U;
                alu_src_a  = 1'b1;
                alu_src_b  = 1'b1;
                rf_wr_sel  = c_wr_sel_alu;
                inst_class = CLS_ALU;
            end
            OPC_JAL: begin
                immed_src  = IMM_J;
                rf_wr_sel  = c_wr_sel_pc4;
                inst_class = CLS_JAL;
            end
            OPC_JALR: begin
                immed_src  = IMM_I;
                rf_wr_sel  = c_wr_sel_pc4;
                inst_class = CLS_JALR;
            end
            OPC_BRANCH: begin
                immed_src  = IMM_B;
                inst_class = CLS_BRANCH;
            end
            OPC_LOAD: begin
                immed_src  = IMM_I;
                alu_src_b  = 1'b1;
                rf_wr_sel  = c_wr_sel_mem;
                inst_class = CLS_LOAD;
            end
            OPC_STORE: begin
                immed_src  = IMM_S;
                alu_src_b  = 1'b1;
                inst_class = CLS_STORE;
            end
            default: begin
                inst_class = CLS_ILLEGAL;
            end
        endcase
    end

endmodule : ctrl_decoder
`default_nettype wire

// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_ctrl
//  Description : Main control FSM of the multicycle OTTER core. Sequences
//                FETCH / DECODE / EXEC / MEM / WB and drives the datapath
//                selects and PC, register-file and memory strobes.
//  Options     : ILLEGAL_INST_TRAP_EN - illegal instructions halt in TRAP
//                (sticky until rst); otherwise they execute as a NOP.
//  Revision    : 1.0 - initial release
// ============================================================================
module multicycle_ctrl
    import otter_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] inst,
    input  logic        br_taken,
    input  logic        mem_ack,
    output logic        ir_we,
    output logic        pc_we,
    output logic [1:0]  pc_src,
    output logic [2:0]  immed_src,
    output logic        alu_src_a,
    output logic        alu_src_b,
    output logic [3:0]  alu_fun,
    output logic        rf_we,
    output logic [1:0]  rf_wr_sel,
    output logic        mem_rden1,
    output logic        mem_rden2,
    output logic        mem_wren2,
    output logic        trap
);

    state_t      r_state;
    state_t      w_next_state;

    immed_src_t  w_dec_immed_src;
    logic [3:0]  w_dec_alu_fun;
    logic        w_dec_alu_src_a;
    logic        w_dec_alu_src_b;
    logic [1:0]  w_dec_rf_wr_sel;
    inst_class_t w_dec_class;

    logic        w_ir_we;
    logic        w_pc_we;
    logic [1:0]  w_pc_src;
    logic [2:0]  w_immed_src;
    logic        w_alu_src_a;
    logic        w_alu_src_b;
    logic [3:0]  w_alu_fun;
    logic        w_rf_we;
    logic [1:0]  w_rf_wr_sel;
    logic        w_mem_rden1;
    logic        w_mem_rden2;
    logic        w_mem_wren2;
    logic        w_trap;

    ctrl_decoder u_decoder (
        .inst       (inst),
        .immed_src  (w_dec_immed_src),
        .alu_fun    (w_dec_alu_fun),
        .alu_src_a  (w_dec_alu_src_a),
        .alu_src_b  (w_dec_alu_src_b),
        .rf_wr_sel  (w_dec_rf_wr_sel),
        .inst_class (w_dec_class)
    );

    // State register; reset drops any outstanding memory request
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and Moore outputs, with decoded fields overlaid per state
    always_comb begin
        w_next_state = r_state;
        w_ir_we      = 1'b0;
        w_pc_we      = 1'b0;
        w_pc_src     = c_pc_src_plus4;
        w_immed_src  = IMM_I;
        w_alu_src_a  = 1'b0;
        w_alu_src_b  = 1'b0;
        w_alu_fun    = c_alu_add;
        w_rf_we      = 1'b0;
        w_rf_wr_sel  = c_wr_sel_pc4;
        w_mem_rden1  = 1'b0;
        w_mem_rden2  = 1'b0;
        w_mem_wren2  = 1'b0;
        w_trap       = 1'b0;
        case (r_state)
            ST_FETCH: begin
                w_mem_rden1 = 1'b1;
                if (mem_ack) begin
                    w_ir_we      = 1'b1;
                    w_next_state = ST_DECODE;
                end
            end
            ST_DECODE: begin
                w_immed_src = w_dec_immed_src;
`ifdef ILLEGAL_INST_TRAP_EN
                w_next_state = (w_dec_class == CLS_ILLEGAL) ? ST_TRAP : ST_EXEC;
`else
                w_next_state = ST_EXEC;
`endif
            end
            ST_EXEC: begin
                w_immed_src  = w_dec_immed_src;
                w_alu_src_a  = w_dec_alu_src_a;
                w_alu_src_b  = w_dec_alu_src_b;
                w_alu_fun    = w_dec_alu_fun;
                w_next_state = ST_FETCH;
                case (w_dec_class)
                    CLS_ALU, CLS_JAL, CLS_JALR: begin
                        w_rf_we     = 1'b1;
                        w_rf_wr_sel = w_dec_rf_wr_sel;
                        w_pc_we     = 1'b1;
                        w_pc_src    = (w_dec_class == CLS_JAL)  ? c_pc_src_jal  :
                                      (w_dec_class == CLS_JALR) ? c_pc_src_jalr :
                                                                  c_pc_src_plus4;
                    end
                    CLS_BRANCH: begin
                        w_pc_we  = 1'b1;
                        w_pc_src = br_taken ? c_pc_src_branch : c_pc_src_plus4;
                    end
                    CLS_LOAD, CLS_STORE: begin
                        w_next_state = ST_MEM;
                    end
                    default: begin
                        // Illegal instruction retires as a NOP
                        w_pc_we  = 1'b1;
                        w_pc_src = c_pc_src_plus4;
                    end
                endcase
            end
            ST_MEM: begin
                w_immed_src = w_dec_immed_src;
                if (w_dec_class == CLS_STORE) begin
                    w_mem_wren2 = 1'b1;
                    if (mem_ack) begin
                        w_pc_we      = 1'b1;
                        w_pc_src     = c_pc_src_plus4;
                        w_next_state = ST_FETCH;
                    end
                end else begin
                    w_mem_rden2 = 1'b1;
                    if (mem_ack) begin
                        w_next_state = ST_WB;
                    end
                end
            end
            ST_WB: begin
                w_immed_src  = w_dec_immed_src;
                w_rf_we      = 1'b1;
                w_rf_wr_sel  = c_wr_sel_mem;
                w_pc_we      = 1'b1;
                w_pc_src     = c_pc_src_plus4;
                w_next_state = ST_FETCH;
            end
            ST_TRAP: begin
`ifdef ILLEGAL_INST_TRAP_EN
                w_trap       = 1'b1;
                w_next_state = ST_TRAP;
`else
                w_next_state = ST_FETCH;
`endif
            end
            default: begin
                w_next_state = ST_FETCH;
            end
        endcase
    end

    // Strobes are forced low while reset is asserted
    assign ir_we     = w_ir_we     & ~rst;
    assign pc_we     = w_pc_we     & ~rst;
    assign rf_we     = w_rf_we     & ~rst;
    assign mem_rden1 = w_mem_rden1 & ~rst;
    assign mem_rden2 = w_mem_rden2 & ~rst;
    assign mem_wren2 = w_mem_wren2 & ~rst;

    assign pc_src    = w_pc_src;
    assign immed_src = w_immed_src;
    assign alu_src_a = w_alu_src_a;
    assign alu_src_b = w_alu_src_b;
    assign alu_fun   = w_alu_fun;
    assign rf_wr_sel = w_rf_wr_sel;

`ifdef ILLEGAL_INST_TRAP_EN
    assign trap = w_trap;
`else
    // Trap state is unreachable in this build
    logic w_unused_trap;
    assign w_unused_trap = w_trap;
    assign trap          = 1'b0;
`endif

endmodule : multicycle_ctrl
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multicycle_ctrl
//  Description : Scoreboard bench for multicycle_ctrl. Each stimulus cycle
//                pushes the hand-computed output vector; a monitor pops and
//                compares it on the falling edge of the same cycle.
//  Options     : ILLEGAL_INST_TRAP_EN selects the trap expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_ctrl;

    localparam logic [31:0] c_addi  = 32'h00500093;
    localparam logic [31:0] c_lw    = 32'h00802103;
    localparam logic [31:0] c_beq   = 32'h00208463;
    localparam logic [31:0] c_srai  = 32'h4020D093;
    localparam logic [31:0] c_and   = 32'h0020F0B3;
    localparam logic [31:0] c_lui   = 32'h000010B7;
    localparam logic [31:0] c_auipc = 32'h00001097;
    localparam logic [31:0] c_jal   = 32'h008000EF;
    localparam logic [31:0] c_jalr  = 32'h000080E7;
    localparam logic [31:0] c_sw    = 32'h00112223;
    localparam logic [31:0] c_ill   = 32'hFFFFFFFF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] inst = 32'h0;
    logic        br_taken = 1'b0;
    logic        mem_ack = 1'b0;

    logic        ir_we, pc_we, alu_src_a, alu_src_b, rf_we;
    logic        mem_rden1, mem_rden2, mem_wren2, trap;
    logic [1:0]  pc_src, rf_wr_sel;
    logic [2:0]  immed_src;
    logic [3:0]  alu_fun;

    multicycle_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .inst      (inst),
        .br_taken  (br_taken),
        .mem_ack   (mem_ack),
        .ir_we     (ir_we),
        .pc_we     (pc_we),
        .pc_src    (pc_src),
        .immed_src (immed_src),
        .alu_src_a (alu_src_a),
        .alu_src_b (alu_src_b),
        .alu_fun   (alu_fun),
        .rf_we     (rf_we),
        .rf_wr_sel (rf_wr_sel),
        .mem_rden1 (mem_rden1),
        .mem_rden2 (mem_rden2),
        .mem_wren2 (mem_wren2),
        .trap      (trap)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [19:0] vec;
        string       name;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    logic [19:0] act;
    assign act = {ir_we, pc_we, pc_src, immed_src, alu_src_a, alu_src_b, alu_fun,
                  rf_we, rf_wr_sel, mem_rden1, mem_rden2, mem_wren2, trap};

    // Output vector in the same bit order as 'act'
    function automatic logic [19:0] ov(
        input logic       irw,
        input logic       pcw,
        input logic [1:0] pcs,
        input logic [2:0] imm,
        input logic       a,
        input logic       b,
        input logic [3:0] fn,
        input logic       rfw,
        input logic [1:0] sel,
        input logic       r1,
        input logic       r2,
        input logic       w2,
        input logic       t
    );
        return {irw, pcw, pcs, imm, a, b, fn, rfw, sel, r1, r2, w2, t};
    endfunction

    logic [19:0] v_zero, v_f_ack, v_f_wait;

    // Monitor: pop one expectation per cycle that has one queued
    always @(negedge clk) begin
        exp_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            n_checks++;
            if (act !== e.vec) begin
                n_errors++;
                $display("FAIL %s: got %05h expected %05h", e.name, act, e.vec);
            end
        end
    end

    // One stimulus cycle: drive inputs after the edge, queue expectation
    task automatic cyc(input logic r, input logic [31:0] i, input logic br,
                       input logic ack, input logic [19:0] v, input string nm);
        @(posedge clk);
        #1;
        rst      = r;
        inst     = i;
        br_taken = br;
        mem_ack  = ack;
        sb_q.push_back('{vec: v, name: nm});
    endtask

    initial begin
        v_zero   = 20'h0;
        v_f_ack  = ov(1, 0, 2'd0, 3'd0, 0, 0, 4'h0, 0, 2'd0, 1, 0, 0, 0);
        v_f_wait = ov(0, 0, 2'd0, 3'd0, 0, 0, 4'h0, 0, 2'd0, 1, 0, 0, 0);

        // Reset holds every output low, ack ignored
        cyc(1, 32'h0, 0, 0, v_zero, "reset");
        cyc(1, 32'h0, 0, 1, v_zero, "reset_ack");

        // addi, zero-wait fetch; stray ack in DECODE/EXEC ignored
        cyc(0, c_addi, 0, 1, v_f_ack, "addi_fetch");
        cyc(0, c_addi, 0, 1, v_zero, "addi_dec");
        cyc(0, c_addi, 0, 1, ov(0, 1, 2'd0, 3'd0, 0, 1, 4'b0000, 1, 2'd3, 0, 0, 0, 0), "addi_exec");

        // lw with two wait cycles in MEM: 7 cycles total
        cyc(0, c_lw, 0, 1, v_f_ack, "lw_fetch");
        cyc(0, c_lw, 0, 0, v_zero, "lw_dec");
        cyc(0, c_lw, 0, 0, ov(0, 0, 2'd0, 3'd0, 0, 1, 4'h0, 0, 2'd0, 0, 0, 0, 0), "lw_exec");
        cyc(0, c_lw, 0, 0, ov(0, 0, 2'd0, 3'd0, 0, 0, 4'h0, 0, 2'd0, 0, 1, 0, 0), "lw_mem0");
        cyc(0, c_lw, 0, 0, ov(0, 0, 2'd0, 3'd0, 0, 0, 4'h0, 0, 2'd0, 0, 1, 0, 0), "lw_mem1");
        cyc(0, c_lw, 0, 1, ov(0, 0, 2'd0, 3'd0, 0, 0, 4'h0, 0, 2'd0, 0, 1, 0, 0), "lw_mem2");
        cyc(0, c_lw, 0, 0, ov(0, 1, 2'd0, 3'd0, 0, 0, 4'h0, 1, 2'd2, 0, 0, 0, 0), "lw_wb");

        // beq taken then not taken
        cyc(0, c_beq, 0, 1, v_f_ack, "beq_t_fetch");
        cyc(0, c_beq, 1, 0, ov(0, 0, 2'd0, 3'd2, 0, 0, 4'h0, 0, 2'd0, 0, 0, 0, 0), "beq_t_dec");
        cyc(0, c_beq, 1, 0, ov(0, 1, 2'd2, 3'd2, 0, 0, 4'h0, 0, 2'd0, 0, 0, 0, 0), "beq_t_exec");
        cyc(0, c_beq, 0, 1, v_f_ack, "beq_n_fetch");
        cyc(0, c_beq, 0, 0, ov(0, 0, 2'd0, 3'd2, 0, 0, 4'h0, 0, 2'd0, 0, 0, 0, 0), "beq_n_dec");
        cyc(0, c_beq, 0, 0, ov(0, 1, 2'd0, 3'd2, 0, 0, 4'h0, 0, 2'd0, 0, 0, 0, 0), "beq_n_exec");

        // srai
        cyc(0, c_srai, 0, 1, v_f_ack, "srai_fetch");
        cyc(0, c_srai, 0, 0, v_zero, "srai_dec");
        cyc(0, c_srai, 0, 0, ov(0, 1, 2'd0, 3'd0, 0, 1, 4'b1101, 1, 2'd3, 0, 0, 0, 0), "srai_exec");

        // and, with one fetch wait cycle
        cyc(0, c_and, 0, 0, v_f_wait, "and_fetch_wait");
        cyc(0, c_and, 0, 1, v_f_ack, "and_fetch");
        cyc(0, c_and, 0, 0, v_zero, "and_dec");
        cyc(0, c_and, 0, 0, ov(0, 1, 2'd0, 3'd0, 0, 0, 4'b0111, 1, 2'd3, 0, 0, 0, 0), "and_exec");

        // lui
        cyc(0, c_lui, 0, 1, v_f_ack, "lui_fetch");
        cyc(0, c_lui, 0, 0, ov(0, 0, 2'd0, 3'd3, 0, 0, 4'h0, 0, 2'd0, 0, 0, 0, 0), "lui_dec");
        cyc(0, c_lui, 0, 0, ov(0, 1, 2'd0, 3'd3, 0, 1, 4'b1001, 1, 2'd3, 0, 0, 0, 0), "lui_exec");

        // auipc
        cyc(0, c_auipc, 0, 1, v_f_ack, "auipc_fetch");
        cyc(0, c_auipc, 0, 0, ov(0, 0, 2'd0, 3'd3, 0, 0, 4'h0, 0, 2'd0, 0, 0, 0, 0), "auipc_dec");
        cyc(0, c_auipc, 0, 0, ov(0, 1, 2'd0, 3'd3, 1, 1, 4'b0000, 1, 2'd3, 0, 0, 0, 0), "auipc_exec");

        // jal / jalr
        cyc(0, c_jal, 0, 1, v_f_ack, "jal_fetch");
        cyc(0, c_jal, 0, 0, ov(0, 0, 2'd0, 3'd4, 0, 0, 4'h0, 0, 2'd0, 0, 0, 0, 0), "jal_dec");
        cyc(0, c_jal, 0, 0, ov(0, 1, 2'd3, 3'd4, 0, 0, 4'h0, 1, 2'd0, 0, 0, 0, 0), "jal_exec");
        cyc(0, c_jalr, 0, 1, v_f_ack, "jalr_fetch");
        cyc(0, c_jalr, 0, 0, v_zero, "jalr_dec");
        cyc(0, c_jalr, 0, 0, ov(0, 1, 2'd1, 3'd0, 0, 0, 4'h0, 1, 2'd0, 0, 0, 0, 0), "jalr_exec");

        // sw with one MEM wait cycle
        cyc(0, c_sw, 0, 1, v_f_ack, "sw_fetch");
        cyc(0, c_sw, 0, 0, ov(0, 0, 2'd0, 3'd1, 0, 0, 4'h0, 0, 2'd0, 0, 0, 0, 0), "sw_dec");
        cyc(0, c_sw, 0, 0, ov(0, 0, 2'd0, 3'd1, 0, 1, 4'h0, 0, 2'd0, 0, 0, 0, 0), "sw_exec");
        cyc(0, c_sw, 0, 0, ov(0, 0, 2'd0, 3'd1, 0, 0, 4'h0, 0, 2'd0, 0, 0, 1, 0), "sw_mem0");
        cyc(0, c_sw, 0, 1, ov(0, 1, 2'd0, 3'd1, 0, 0, 4'h0, 0, 2'd0, 0, 0, 1, 0), "sw_mem1");

        // Illegal instruction
        cyc(0, c_ill, 0, 1, v_f_ack, "ill_fetch");
        cyc(0, c_ill, 0, 0, v_zero, "ill_dec");
`ifdef ILLEGAL_INST_TRAP_EN
        cyc(0, c_ill, 0, 1, ov(0, 0, 2'd0, 3'd0, 0, 0, 4'h0, 0, 2'd0, 0, 0, 0, 1), "trap0");
        cyc(0, c_addi, 0, 1, ov(0, 0, 2'd0, 3'd0, 0, 0, 4'h0, 0, 2'd0, 0, 0, 0, 1), "trap1");
        cyc(0, c_addi, 0, 0, ov(0, 0, 2'd0, 3'd0, 0, 0, 4'h0, 0, 2'd0, 0, 0, 0, 1), "trap2");
`else
        cyc(0, c_ill, 0, 0, ov(0, 1, 2'd0, 3'd0, 0, 0, 4'h0, 0, 2'd0, 0, 0, 0, 0), "ill_nop_exec");
        cyc(0, c_ill, 0, 0, v_f_wait, "ill_back_fetch");
`endif
        cyc(1, c_ill, 0, 0, v_zero, "reset2");

        // Reset pulsed during a load's MEM wait
        cyc(0, c_lw, 0, 1, v_f_ack, "rl_fetch");
        cyc(0, c_lw, 0, 0, v_zero, "rl_dec");
        cyc(0, c_lw, 0, 0, ov(0, 0, 2'd0, 3'd0, 0, 1, 4'h0, 0, 2'd0, 0, 0, 0, 0), "rl_exec");
        cyc(0, c_lw, 0, 0, ov(0, 0, 2'd0, 3'd0, 0, 0, 4'h0, 0, 2'd0, 0, 1, 0, 0), "rl_mem");
        cyc(1, c_lw, 0, 0, v_zero, "rl_rst_mid_mem");
        cyc(1, c_lw, 0, 1, v_zero, "rl_rst_hold");
        cyc(0, c_lw, 0, 0, v_f_wait, "rl_post_rst_fetch");
        cyc(0, c_addi, 0, 1, v_f_ack, "rl_addi_fetch");
        cyc(0, c_addi, 0, 0, v_zero, "rl_addi_dec");
        cyc(0, c_addi, 0, 0, ov(0, 1, 2'd0, 3'd0, 0, 1, 4'b0000, 1, 2'd3, 0, 0, 0, 0), "rl_addi_exec");

        // Let the monitor drain, then confirm nothing was left unchecked
        @(negedge clk);
        #1;
        n_checks++;
        if (sb_q.size() != 0) begin
            n_errors++;
            $display("FAIL drain: got %0d pending expected 0", sb_q.size());
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_multicycle_ctrl
`default_nettype wire
